// File: rtl/des_f_sbox_ctrl.sv
// DES round-function sequencer: forms E(R)^K, addresses the eight S-box ROMs,
// waits out their read latency and returns P(S-box result) through a valid/ready port.
module des_f_sbox_ctrl #(
  parameter int ROM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_r_in,
  input  logic [47:0] i_k_in,
  output logic [15:0] o_sbox_row,
  output logic [31:0] o_sbox_col,
  input  logic [31:0] i_sbox_dout,
  output logic [31:0] o_f_out,
  output logic        o_out_valid,
  input  logic        i_out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);

  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
    $error("des_f_sbox_ctrl: ROM_LAT=%0d is outside the legal range 1..4", ROM_LAT);
  end

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_row;
  logic [31:0] r_col;
  logic [31:0] r_f;
  logic [47:0] w_x;
  logic [15:0] w_row;
  logic [31:0] w_col;
  logic [31:0] w_p;
  logic        w_accept;
  logic        w_release;

  assign w_accept  = i_in_valid & r_in_ready;
  assign w_release = r_out_valid & i_out_ready;

  // E expansion: each 6-bit group borrows the neighbouring bit on either side, wrapping at the ends.
  assign w_x = {i_r_in[0], i_r_in[31:27], i_r_in[28:23], i_r_in[24:19], i_r_in[20:15],
                i_r_in[16:11], i_r_in[12:7], i_r_in[8:3], i_r_in[4:0], i_r_in[31]} ^ i_k_in;

  for (genvar g = 0; g < 8; g++) begin : g_addr
    assign w_row[15-2*g -: 2] = {w_x[47-6*g], w_x[42-6*g]};
    assign w_col[31-4*g -: 4] = w_x[46-6*g -: 4];
  end

  assign w_p = {i_sbox_dout[16], i_sbox_dout[25], i_sbox_dout[12], i_sbox_dout[11],
                i_sbox_dout[3],  i_sbox_dout[20], i_sbox_dout[4],  i_sbox_dout[15],
                i_sbox_dout[31], i_sbox_dout[17], i_sbox_dout[9],  i_sbox_dout[6],
                i_sbox_dout[27], i_sbox_dout[14], i_sbox_dout[1],  i_sbox_dout[22],
                i_sbox_dout[30], i_sbox_dout[24], i_sbox_dout[8],  i_sbox_dout[18],
                i_sbox_dout[0],  i_sbox_dout[5],  i_sbox_dout[29], i_sbox_dout[23],
                i_sbox_dout[13], i_sbox_dout[19], i_sbox_dout[2],  i_sbox_dout[26],
                i_sbox_dout[10], i_sbox_dout[21], i_sbox_dout[28], i_sbox_dout[7]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ADDR;
      S_ADDR:  w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 2'd0) w_next = S_DONE;
      S_DONE:  if (w_release) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it stays low while reset is held.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_cnt       <= 2'd0;
      r_row       <= 16'd0;
      r_col       <= 32'd0;
      r_f         <= 32'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
      if (r_state == S_IDLE && w_accept) begin
        r_row <= w_row;
        r_col <= w_col;
      end
      if (r_state == S_ADDR) begin
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (r_state == S_WAIT && r_cnt == 2'd0) begin
        r_f         <= w_p;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_sbox_row  = r_row;
  assign o_sbox_col  = r_col;
  assign o_f_out     = r_f;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_des_f_sbox_ctrl.sv
// Self-checking bench for des_f_sbox_ctrl: S-box ROM models at latency 1 and 3,
// and a table-driven DES f reference built from the standard E, S and P tables.
module tb_des_f_sbox_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inValid, inValid3, outReady, outReady3;
  logic [31:0] rIn;
  logic [47:0] kIn;
  logic        inReady, outValid, inReady3, outValid3;
  logic [15:0] sboxRow, sboxRow3;
  logic [31:0] sboxCol, sboxCol3, sboxDout, sboxDout3, fOut, fOut3;
  logic [31:0] romPipe3 [3];
  int          testCount = 0;
  int          failCount = 0;

  int eTab [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
                    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
  int pTab [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  logic [255:0] sboxTab [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  always #5 clk = ~clk;

  des_f_sbox_ctrl #(.ROM_LAT(1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_r_in(rIn), .i_k_in(kIn), .o_sbox_row(sboxRow), .o_sbox_col(sboxCol),
    .i_sbox_dout(sboxDout), .o_f_out(fOut), .o_out_valid(outValid), .i_out_ready(outReady));

  des_f_sbox_ctrl #(.ROM_LAT(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_in_valid(inValid3), .o_in_ready(inReady3),
    .i_r_in(rIn), .i_k_in(kIn), .o_sbox_row(sboxRow3), .o_sbox_col(sboxCol3),
    .i_sbox_dout(sboxDout3), .o_f_out(fOut3), .o_out_valid(outValid3), .i_out_ready(outReady3));

  // ROM model: eight S-box lookups addressed by the DUT's row/col buses.
  function automatic logic [31:0] romLookup(input logic [15:0] row, input logic [31:0] col);
    logic [31:0] d;
    int idx;
    d = '0;
    for (int b = 0; b < 8; b++) begin
      idx = 16 * int'(row[15-2*b -: 2]) + int'(col[31-4*b -: 4]);
      d[31-4*b -: 4] = sboxTab[b][255-4*idx -: 4];
    end
    return d;
  endfunction

  always @(posedge clk) sboxDout <= romLookup(sboxRow, sboxCol);

  always @(posedge clk) begin
    romPipe3[0] <= romLookup(sboxRow3, sboxCol3);
    romPipe3[1] <= romPipe3[0];
    romPipe3[2] <= romPipe3[1];
  end
  assign sboxDout3 = romPipe3[2];

  // Reference f, written in DES bit numbering (bit n of a w-bit word is index w-n).
  function automatic logic [47:0] refX(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    for (int i = 1; i <= 48; i++) x[48-i] = r[32-eTab[i-1]] ^ k[48-i];
    return x;
  endfunction

  function automatic logic [31:0] refF(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, f;
    int b1, b6, mid, idx;
    x = refX(r, k);
    s = '0;
    f = '0;
    for (int b = 0; b < 8; b++) begin
      b1  = int'(x[48-(6*b+1)]);
      b6  = int'(x[48-(6*b+6)]);
      mid = 8 * int'(x[48-(6*b+2)]) + 4 * int'(x[48-(6*b+3)]) + 2 * int'(x[48-(6*b+4)]) + int'(x[48-(6*b+5)]);
      idx = 32 * b1 + 16 * b6 + mid;
      s[31-4*b -: 4] = sboxTab[b][255-4*idx -: 4];
    end
    for (int i = 1; i <= 32; i++) f[32-i] = s[32-pTab[i-1]];
    return f;
  endfunction

  function automatic logic [15:0] expRowOf(input logic [47:0] x);
    logic [15:0] rw;
    for (int b = 0; b < 8; b++) rw[15-2*b -: 2] = {x[48-(6*b+1)], x[48-(6*b+6)]};
    return rw;
  endfunction

  function automatic logic [31:0] expColOf(input logic [47:0] x);
    logic [31:0] cl;
    for (int b = 0; b < 8; b++)
      cl[31-4*b -: 4] = {x[48-(6*b+2)], x[48-(6*b+3)], x[48-(6*b+4)], x[48-(6*b+5)]};
    return cl;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (inReady !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (inReady !== 1'b1) begin
      testCount++; failCount++;
      $display("[TB] FAIL wait_idle: in_ready=%0b, expected 1 within 50 cycles", inReady);
    end
  endtask

  task automatic test_reset();
    inValid = 1'b0; inValid3 = 1'b0; outReady = 1'b0; outReady3 = 1'b0;
    rIn = '0; kIn = '0;
    rstn = 1'b0;
    #23;
    testCount++; if (inReady !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in_ready: got %0b, expected 0", inReady); end
    testCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %0b, expected 0", outValid); end
    testCount++; if (sboxRow !== 16'd0 || sboxCol !== 32'd0) begin failCount++; $display("[TB] FAIL reset_addr: row %h col %h, expected 0", sboxRow, sboxCol); end
    testCount++; if (fOut !== 32'd0) begin failCount++; $display("[TB] FAIL reset_f_out: got %h, expected 0", fOut); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    testCount++; if (inReady !== 1'b0) begin failCount++; $display("[TB] FAIL release_in_ready_before_edge: got %0b, expected 0", inReady); end
    tick();
    testCount++; if (inReady !== 1'b1 || inReady3 !== 1'b1) begin failCount++; $display("[TB] FAIL release_in_ready: got %0b/%0b, expected 1/1", inReady, inReady3); end
  endtask

  task automatic runSingle(input string name, input logic [31:0] r, input logic [47:0] k,
                           input logic [47:0] expX, input logic [31:0] expF);
    waitIdle();
    outReady = 1'b1;
    rIn = r; kIn = k; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    testCount++; if (sboxRow !== expRowOf(expX)) begin failCount++; $display("[TB] FAIL %s_row: got %h, expected %h", name, sboxRow, expRowOf(expX)); end
    testCount++; if (sboxCol !== expColOf(expX)) begin failCount++; $display("[TB] FAIL %s_col: got %h, expected %h", name, sboxCol, expColOf(expX)); end
    testCount++; if (inReady !== 1'b0 || outValid !== 1'b0) begin failCount++; $display("[TB] FAIL %s_busy: in_ready %0b out_valid %0b, expected 0/0", name, inReady, outValid); end
    tick();
    testCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL %s_early_valid: got %0b, expected 0", name, outValid); end
    tick();
    testCount++; if (outValid !== 1'b1 || fOut !== expF) begin failCount++; $display("[TB] FAIL %s_result: valid %0b f_out %h, expected 1 %h", name, outValid, fOut, expF); end
    tick();
    testCount++; if (outValid !== 1'b0 || inReady !== 1'b1 || fOut !== expF) begin failCount++; $display("[TB] FAIL %s_after: valid %0b ready %0b f_out %h, expected 0 1 %h", name, outValid, inReady, fOut, expF); end
  endtask

  task automatic test_t1();
    runSingle("t1", 32'hF0AAF0AA, 48'h1B02EFFC7072, 48'h6117BA866527, 32'h234AA9BB);
  endtask

  task automatic test_zero();
    runSingle("zero", 32'h0, 48'h0, 48'h0, 32'hD8D8DBBC);
  endtask

  task automatic test_backpressure();
    waitIdle();
    outReady = 1'b0;
    rIn = 32'hF0AAF0AA; kIn = 48'h1B02EFFC7072; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      testCount++;
      if (outValid !== 1'b1 || fOut !== 32'h234AA9BB || inReady !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL bp_hold[%0d]: valid %0b f_out %h ready %0b, expected 1 234aa9bb 0", c, outValid, fOut, inReady);
      end
      if (c < 4) tick();
    end
    outReady = 1'b1;
    tick();
    testCount++; if (outValid !== 1'b0 || inReady !== 1'b1 || fOut !== 32'h234AA9BB) begin failCount++; $display("[TB] FAIL bp_release: valid %0b ready %0b f_out %h, expected 0 1 234aa9bb", outValid, inReady, fOut); end
    tick();
    testCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_single_transfer: valid %0b, expected 0", outValid); end
  endtask

  task automatic test_lat3();
    testCount++; if (inReady3 !== 1'b1) begin failCount++; $display("[TB] FAIL lat3_idle: in_ready %0b, expected 1", inReady3); end
    outReady3 = 1'b1;
    rIn = 32'hF0AAF0AA; kIn = 48'h1B02EFFC7072; inValid3 = 1'b1;
    tick();
    inValid3 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      testCount++;
      if (outValid3 !== (e == 4)) begin
        failCount++;
        $display("[TB] FAIL lat3_edge%0d: out_valid %0b, expected %0b", e, outValid3, (e == 4));
      end
    end
    testCount++; if (fOut3 !== 32'h234AA9BB) begin failCount++; $display("[TB] FAIL lat3_f_out: got %h, expected 234aa9bb", fOut3); end
    tick();
    testCount++; if (outValid3 !== 1'b0 || inReady3 !== 1'b1) begin failCount++; $display("[TB] FAIL lat3_release: valid %0b ready %0b, expected 0 1", outValid3, inReady3); end
  endtask

  task automatic test_reset_midop();
    logic seenValid;
    waitIdle();
    outReady = 1'b1; outReady3 = 1'b1;
    rIn = 32'hF0AAF0AA; kIn = 48'h1B02EFFC7072; inValid = 1'b1; inValid3 = 1'b1;
    tick();
    inValid = 1'b0; inValid3 = 1'b0;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    testCount++;
    if (inReady !== 1'b0 || outValid !== 1'b0 || sboxRow !== 16'd0 || sboxCol !== 32'd0 || fOut !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL midop_async_reset: ready %0b valid %0b row %h col %h f %h, expected all 0", inReady, outValid, sboxRow, sboxCol, fOut);
    end
    testCount++; if (outValid3 !== 1'b0 || sboxRow3 !== 16'd0 || fOut3 !== 32'd0) begin failCount++; $display("[TB] FAIL midop_async_reset_lat3: valid %0b row %h f %h, expected 0", outValid3, sboxRow3, fOut3); end
    tick();
    @(negedge clk);
    rstn = 1'b1;
    seenValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (outValid === 1'b1 || outValid3 === 1'b1) seenValid = 1'b1;
    end
    testCount++; if (seenValid !== 1'b0) begin failCount++; $display("[TB] FAIL midop_no_valid: saw out_valid %0b, expected 0", seenValid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rs [3];
    logic [47:0] ks [3];
    int acceptCycle [$];
    int nSent, nRecv, cyc;
    logic acc;
    for (int i = 0; i < 3; i++) begin
      rs[i] = $urandom;
      ks[i] = {16'($urandom), 32'($urandom)};
    end
    waitIdle();
    outReady = 1'b1;
    nSent = 0; nRecv = 0; cyc = 0;
    rIn = rs[0]; kIn = ks[0]; inValid = 1'b1;
    while (nRecv < 3 && cyc < 60) begin
      acc = inValid & inReady;
      tick();
      cyc++;
      if (acc) begin
        acceptCycle.push_back(cyc);
        nSent++;
        if (nSent < 3) begin
          rIn = rs[nSent]; kIn = ks[nSent];
        end else begin
          inValid = 1'b0;
        end
      end
      if (outValid === 1'b1 && nRecv < 3) begin
        testCount++;
        if (fOut !== refF(rs[nRecv], ks[nRecv])) begin
          failCount++;
          $display("[TB] FAIL b2b_result[%0d]: got %h, expected %h", nRecv, fOut, refF(rs[nRecv], ks[nRecv]));
        end
        nRecv++;
      end
    end
    inValid = 1'b0;
    testCount++; if (nRecv != 3 || nSent != 3) begin failCount++; $display("[TB] FAIL b2b_count: accepts %0d results %0d, expected 3 3", nSent, nRecv); end
    if (acceptCycle.size() == 3) begin
      testCount++;
      if (acceptCycle[1] - acceptCycle[0] != 1 + 3 || acceptCycle[2] - acceptCycle[1] != 1 + 3) begin
        failCount++;
        $display("[TB] FAIL b2b_spacing: gaps %0d %0d, expected 4 4", acceptCycle[1] - acceptCycle[0], acceptCycle[2] - acceptCycle[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, expF;
    logic [47:0] k, x;
    int lat, stall;
    for (int t = 0; t < 24; t++) begin
      r = $urandom;
      k = {16'($urandom), 32'($urandom)};
      x = refX(r, k);
      expF = refF(r, k);
      waitIdle();
      rIn = r; kIn = k; inValid = 1'b1; outReady = 1'b0;
      tick();
      inValid = 1'b0;
      testCount++; if (sboxRow !== expRowOf(x) || sboxCol !== expColOf(x)) begin failCount++; $display("[TB] FAIL rand%0d_addr: row %h col %h, expected %h %h", t, sboxRow, sboxCol, expRowOf(x), expColOf(x)); end
      lat = 0;
      while (outValid !== 1'b1 && lat < 12) begin
        tick();
        lat++;
      end
      testCount++; if (lat != 2) begin failCount++; $display("[TB] FAIL rand%0d_latency: got %0d edges, expected 2", t, lat); end
      testCount++; if (fOut !== expF) begin failCount++; $display("[TB] FAIL rand%0d_f_out: got %h, expected %h", t, fOut, expF); end
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        tick();
        testCount++; if (outValid !== 1'b1 || fOut !== expF) begin failCount++; $display("[TB] FAIL rand%0d_stall: valid %0b f %h, expected 1 %h", t, outValid, fOut, expF); end
      end
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      testCount++; if (outValid !== 1'b0 || inReady !== 1'b1) begin failCount++; $display("[TB] FAIL rand%0d_release: valid %0b ready %0b, expected 0 1", t, outValid, inReady); end
    end
  endtask

  initial begin
    test_reset();
    test_t1();
    test_zero();
    test_backpressure();
    test_lat3();
    test_reset_midop();
    test_t1();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
